instr_fetch: RTL and testbench

//  Instruction fetch unit: owns the PC, issues reads to a synchronous instruction memory and

---
 rtl/rv_pkg.sv | 27 ++
 rtl/fetch_buffer.sv | 85 ++++++++
 rtl/instr_fetch.sv | 136 +++++++++++++
 tb/tb_instr_fetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the fetch front end.
//  - NOP_INST           : encoding of addi x0,x0,0, driven when no instruction is offered
//  - DEFAULT_RESET_ADDR : PC fetched first after reset unless overridden
//  - fetch_state_e      : fetch sequencer states
//  - fetch_entry_t      : one buffered instruction together with its PC tag
package rv_pkg;

    localparam logic [31:0] NOP_INST           = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Instruction addresses must be word aligned; anything else is a fault.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs until decode takes them.
// Ports:
//  i_clk    clock, rising edge
//  i_rst    asynchronous active-high reset, empties the FIFO
//  i_push   write i_entry at the tail
//  i_entry  entry to write
//  i_pop    drop the head entry
//  i_flush  empty the FIFO; wins over push and pop in the same cycle
//  o_head   head entry, straight from storage (registered)
//  o_count  number of valid entries
module fetch_buffer
    import rv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  fetch_entry_t       i_entry,
    input  logic               i_pop,
    input  logic               i_flush,
    output fetch_entry_t       o_head,
    output logic [CNT_W-1:0]   o_count
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointer and occupancy update. DEPTH is a power of two, so the pointers
    // wrap by simple overflow. A push into a full FIFO is only taken when a
    // pop frees a slot in the same cycle.
    always_comb begin
        do_pop   = i_pop && (count_q != '0);
        do_push  = i_push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while count_q says they are valid.
    always_ff @(posedge i_clk) begin
        if (do_push && !i_flush) begin
            mem_q[wr_ptr_q] <= i_entry;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads a synchronous instruction memory and
// hands {instruction, PC, PC+4} to decode over a valid/ready handshake. Redirects
// from the branch/jump logic flush everything fetched down the wrong path.
// Ports:
//  i_clk, i_rst            clock; asynchronous active-high reset
//  o_imem_ren/o_imem_raddr read request to instruction memory (data returns next cycle)
//  i_imem_rdata            read data, valid exactly one cycle after o_imem_ren
//  o_inst_valid/i_dec_ready handshake to decode
//  o_inst/o_inst_pc/o_inst_pc_plus4  delivered instruction, its PC and link address
//  i_redirect/i_redirect_pc taken branch/jump and its target
//  o_fault/o_fault_pc      sticky misaligned-target indication and the offending target
module instr_fetch
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR,
    parameter int          BUF_DEPTH  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_ren,
    output logic [31:0] o_imem_raddr,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_valid,
    input  logic        i_dec_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic [31:0] o_inst_pc_plus4,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_fault,
    output logic [31:0] o_fault_pc
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      inflight_pc_q;
    logic             inflight_q, inflight_d;
    logic             fault_q, fault_d;
    logic [31:0]      fault_pc_q, fault_pc_d;

    logic             ren;
    logic             valid;
    logic             pop;
    logic             push;
    logic             flush;
    logic             credit_ok;
    logic             redirect_taken;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;
    logic [CNT_W-1:0] buf_count;

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_entry (push_entry),
        .i_pop   (pop),
        .i_flush (flush),
        .o_head  (head),
        .o_count (buf_count)
    );

    // Sequencer, issue credit and redirect handling.
    // A request is only issued when the buffer is guaranteed a slot for its
    // response: buffered + in-flight, less the entry leaving this cycle, must be
    // below the depth. That makes o_imem_ren depend combinationally on
    // i_dec_ready, which keeps full throughput with a two-entry buffer.
    // A redirect hides the buffer head in its own cycle so nothing wrong-path
    // can be handed to decode, and the response landing this cycle is dropped.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;

        redirect_taken = i_redirect && (state_q != FETCH_HALT);
        valid          = (buf_count != '0) && !i_redirect;
        pop            = valid && i_dec_ready;
        credit_ok      = (int'(buf_count) + int'(inflight_q) - int'(pop)) < BUF_DEPTH;
        ren            = (state_q == FETCH_RUN) && !i_redirect && credit_ok;
        push           = inflight_q && !i_redirect;
        flush          = redirect_taken;
        push_entry     = '{pc: inflight_pc_q, inst: i_imem_rdata};
        inflight_d     = ren;

        case (state_q)
            FETCH_BOOT: state_d = FETCH_RUN;
            FETCH_RUN:  state_d = FETCH_RUN;
            FETCH_HALT: state_d = FETCH_HALT;
            default:    state_d = FETCH_HALT;
        endcase

        if (redirect_taken) begin
            fetch_pc_d = i_redirect_pc;
            if (!is_word_aligned(i_redirect_pc)) begin
                state_d    = FETCH_HALT;
                fault_d    = 1'b1;
                fault_pc_d = i_redirect_pc;
            end
        end else if (ren) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= FETCH_BOOT;
            fetch_pc_q    <= RESET_ADDR;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_ADDR;
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= fetch_pc_q;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
        end
    end

    assign o_imem_ren      = ren;
    assign o_imem_raddr    = fetch_pc_q;
    assign o_inst_valid    = valid;
    assign o_inst          = valid ? head.inst : NOP_INST;
    assign o_inst_pc       = valid ? head.pc : 32'h0;
    assign o_inst_pc_plus4 = valid ? head.pc + 32'd4 : 32'h0;
    assign o_fault         = fault_q;
    assign o_fault_pc      = fault_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch. Two instances share clock, reset and decode-ready:
// the main one uses the default reset address, the second one starts at 0x80.
// Each instance talks to its own memory model returning mem[addr>>2] = addr>>2.
// Delivered instructions of the main instance are checked against a queue of
// expected PCs filled by the stimulus code.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirectPc = 32'h0;
    logic        noRedirect = 1'b0;
    logic [31:0] noRedirectPc = 32'h0;

    logic        ren, valid, fault;
    logic [31:0] raddr, rdata, inst, instPc, instPc4, faultPc;
    logic        ren80, valid80, fault80;
    logic [31:0] raddr80, rdata80, inst80, instPc80, instPc480, faultPc80;

    int checks = 0;
    int failures = 0;
    logic [31:0] expQ[$];

    typedef struct {
        logic        ready;
        logic        expRen;
        logic [31:0] expRaddr;
        logic        expValid;
        logic [31:0] expPc;
    } vec_t;
    vec_t tbl[8];

    always #5 clk = ~clk;

    instr_fetch dut (
        .i_clk(clk), .i_rst(rst),
        .o_imem_ren(ren), .o_imem_raddr(raddr), .i_imem_rdata(rdata),
        .o_inst_valid(valid), .i_dec_ready(ready),
        .o_inst(inst), .o_inst_pc(instPc), .o_inst_pc_plus4(instPc4),
        .i_redirect(redirect), .i_redirect_pc(redirectPc),
        .o_fault(fault), .o_fault_pc(faultPc)
    );

    instr_fetch #(.RESET_ADDR(32'h0000_0080), .BUF_DEPTH(2)) dut80 (
        .i_clk(clk), .i_rst(rst),
        .o_imem_ren(ren80), .o_imem_raddr(raddr80), .i_imem_rdata(rdata80),
        .o_inst_valid(valid80), .i_dec_ready(ready),
        .o_inst(inst80), .o_inst_pc(instPc80), .o_inst_pc_plus4(instPc480),
        .i_redirect(noRedirect), .i_redirect_pc(noRedirectPc),
        .o_fault(fault80), .o_fault_pc(faultPc80)
    );

    // Synchronous memories: data for a request appears the following cycle.
    always @(posedge clk) begin
        if (ren)   rdata   <= {2'b00, raddr[31:2]};
        if (ren80) rdata80 <= {2'b00, raddr80[31:2]};
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] pc);
        ready      = rdy;
        redirect   = redir;
        redirectPc = pc;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushStream(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) expQ.push_back(base + 32'(4 * k));
    endtask

    // Scoreboard: every transfer of the main instance must match the queue head.
    always @(negedge clk) begin
        if (valid && ready) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected transfer: got pc %h expected none", instPc);
            end else begin
                logic [31:0] e;
                e = expQ.pop_front();
                checkOutput("xfer pc", instPc, e);
                checkOutput("xfer inst", inst, {2'b00, e[31:2]});
                checkOutput("xfer pc+4", instPc4, e + 32'd4);
            end
        end
    end

    task automatic waitDrain(input int level, input int budget, input string name);
        int n = 0;
        while (expQ.size() > level && n < budget) begin
            nextCycle();
            n++;
        end
        checks++;
        if (expQ.size() > level) begin
            failures++;
            $display("[TB] FAIL %s drain timeout: got %0d pending expected <= %0d", name, expQ.size(), level);
        end
    endtask

    task automatic runStartupTable();
        for (int i = 0; i < 8; i++) begin
            ready = tbl[i].ready;
            @(negedge clk);
            checkOutput($sformatf("c%0d ren", i + 1), 32'(ren), 32'(tbl[i].expRen));
            checkOutput($sformatf("c%0d raddr", i + 1), raddr, tbl[i].expRaddr);
            checkOutput($sformatf("c%0d valid", i + 1), 32'(valid), 32'(tbl[i].expValid));
            checkOutput($sformatf("c%0d raddr80", i + 1), raddr80, tbl[i].expRaddr + 32'h80);
            checkOutput($sformatf("c%0d valid80", i + 1), 32'(valid80), 32'(tbl[i].expValid));
            if (tbl[i].expValid) begin
                checkOutput($sformatf("c%0d pc", i + 1), instPc, tbl[i].expPc);
                checkOutput($sformatf("c%0d pc80", i + 1), instPc80, tbl[i].expPc + 32'h80);
                checkOutput($sformatf("c%0d inst80", i + 1), inst80, (tbl[i].expPc + 32'h80) >> 2);
            end else begin
                checkOutput($sformatf("c%0d nop", i + 1), inst, 32'h0000_0013);
            end
            nextCycle();
        end
    endtask

    task automatic startFromReset();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0);
        repeat (2) nextCycle();
        expQ.delete();
        pushStream(32'h0, 64);
        rst = 1'b0;
        runStartupTable();
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[1] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[2] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[3] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[4] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[5] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[6] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        tbl[7] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10};

        // Startup from reset, full-rate stream.
        startFromReset();

        // Decode stalls for 6 cycles: requests stop, the head is held.
        applyStimulus(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("stall%0d ren", i), 32'(ren), 32'h0);
            checkOutput($sformatf("stall%0d valid", i), 32'(valid), 32'h1);
            checkOutput($sformatf("stall%0d pc", i), instPc, expQ[0]);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 32'h0);
        waitDrain(52, 20, "resume");

        // Redirect to 0x100 with a full buffer.
        applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (3) nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h100);
        expQ.delete();
        pushStream(32'h100, 16);
        @(negedge clk);
        checkOutput("redir cycle valid", 32'(valid), 32'h0);
        checkOutput("redir cycle ren", 32'(ren), 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("redir+1 ren", 32'(ren), 32'h1);
        checkOutput("redir+1 raddr", raddr, 32'h100);
        checkOutput("redir+1 valid", 32'(valid), 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("redir+2 valid", 32'(valid), 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("redir+3 valid", 32'(valid), 32'h1);
        checkOutput("redir+3 pc", instPc, 32'h100);
        nextCycle();
        waitDrain(10, 20, "after redirect");

        // Misaligned redirect: fault and permanent halt until reset.
        applyStimulus(1'b1, 1'b1, 32'h102);
        expQ.delete();
        @(negedge clk);
        checkOutput("fault before edge", 32'(fault), 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checkOutput("fault set", 32'(fault), 32'h1);
                checkOutput("fault pc", faultPc, 32'h102);
            end
            checkOutput($sformatf("halt%0d ren", i), 32'(ren), 32'h0);
            checkOutput($sformatf("halt%0d valid", i), 32'(valid), 32'h0);
            nextCycle();
        end
        checkOutput("fault held", 32'(fault), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("fault cleared", 32'(fault), 32'h0);
        checkOutput("fault pc cleared", faultPc, 32'h0);

        // Restart, then asynchronous reset between clock edges mid-stream.
        startFromReset();
        nextCycle();
        #3;
        rst = 1'b1;
        expQ.delete();
        #1;
        checkOutput("async ren", 32'(ren), 32'h0);
        checkOutput("async raddr", raddr, 32'h0);
        checkOutput("async valid", 32'(valid), 32'h0);
        checkOutput("async inst", inst, 32'h0000_0013);
        checkOutput("async pc", instPc, 32'h0);
        checkOutput("async fault", 32'(fault), 32'h0);
        checkOutput("async raddr80", raddr80, 32'h80);
        checkOutput("async ren80", 32'(ren80), 32'h0);
        checkOutput("async valid80", 32'(valid80), 32'h0);
        startFromReset();

        // Redirect with decode ready and a non-empty buffer.
        applyStimulus(1'b1, 1'b1, 32'h200);
        expQ.delete();
        pushStream(32'h200, 4);
        @(negedge clk);
        checkOutput("redir ready valid", 32'(valid), 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        waitDrain(1, 12, "redirect 0x200");

        // PC wrap from 0xFFFF_FFFC to 0.
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8);
        expQ.delete();
        pushStream(32'hFFFF_FFF8, 5);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        waitDrain(1, 12, "wrap");
        applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (3) nextCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
